mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Moore-style main control state machine for the 8-bit multicycle processor. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select (including the ALU source-A 2:1 mux) and every write enable. It consumes the instruction register opcode and the ALU zero flag, and it stalls on a memory-ready handshake.

Parameters:
OP_RTYPE, 3'b000, R-type ALU opcode
OP_LW, 3'b001, load word opcode
OP_SW, 3'b010, store word opcode
OP_BEQ, 3'b011, branch-if-equal opcode
OP_ADDI, 3'b100, add-immediate opcode
OP_J, 3'b101, jump opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state FETCH
opcode  input  3  opcode field from instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory completes the access this cycle
pcEn  output  1  PC load enable = (pcWrite & memReady-qualified) | (branch & zero)
iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
irWrite  output  1  instruction register load
memToReg  output  1  register writeback select: 0 = ALUOut, 1 = MDR
regDst  output  1  destination register select: 0 = rt, 1 = rd
regWrite  output  1  register file write enable
aluSrcA  output  1  ALU A select: 0 = PC, 1 = regA
aluSrcB  output  2  ALU B select: 00 regB, 01 const 1, 10 sign-ext imm, 11 branch offset
aluOp  output  2  00 add, 01 subtract, 10 decode by funct
pcSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
illegalOp  output  1  one-cycle pulse in DECODE on an undefined opcode
state  output  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Encodings 12–15 return to FETCH on the next edge with all outputs 0.
- Outputs are Moore, decoded from state only; pcEn and FETCH irWrite also depend on memReady/zero. Every output not listed for a state is 0.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=memReady; pcEn=memReady. Holds while memReady=0; goes to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode: LW/SW→MEMADR, RTYPE→EXECUTE, BEQ→BRANCH, ADDI→ADDIEXEC, J→JUMP. Opcodes 110/111→FETCH with illegalOp=1 for this cycle.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD for LW, MEMWR for SW. Opcode is sampled from the stable IR.
- MEMRD: memRead=1, iorD=1. Holds until memReady, then MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1; then FETCH.
- MEMWR: memWrite=1, iorD=1. Holds until memReady, then FETCH. memWrite stays high for the whole stall.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10; then ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1; then FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01; pcEn=zero; then FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00; then ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1; then FETCH.
- JUMP: pcSource=10, pcEn=1; then FETCH.
- Latency with memReady held high: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
- Reset: asynchronous. state=FETCH immediately. While reset is high, pcEn, irWrite, regWrite, memWrite and memRead are forced to 0; the other outputs show FETCH values. On reset deassertion, the first rising edge evaluates FETCH normally. Reset asserted mid-instruction aborts it with no further writes.
- memReady is ignored outside FETCH, MEMRD and MEMWR.
- zero is ignored outside BRANCH.

Test Plan:
- Reset asserted during MEMWR with memReady=0 → state=0 and memWrite=0 within the same cycle; after release, FETCH with memRead=1.
- opcode=000, memReady=1 → states 0,1,6,7,0; regWrite=1 and regDst=1 only in cycle 4; aluOp=10 in cycle 3.
- opcode=001, memReady low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; memToReg=1 and regWrite=1 only in state 4; iorD=1 throughout MEMRD.
- opcode=011 with zero=1, then zero=0 → pcEn=1 and pcSource=01 in BRANCH for the first; pcEn=0 for the second; 3 cycles each.
- opcode=110 → illegalOp pulses exactly one cycle in DECODE; next state FETCH; no regWrite or memWrite asserted.
- opcode=101 plus FETCH stalled 3 cycles → irWrite=0 and pcEn=0 during the stall, 1 on the memReady cycle; JUMP gives pcSource=10, pcEn=1.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main control FSM and the datapath.
// The FSM side uses the master modport; the datapath (or a bench) uses slave.
interface mc_control_fsm_if;
    logic [2:0] opcode;
    logic       zero;
    logic       memReady;
    logic       pcEn;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic [3:0] state;

    modport master (
        input  opcode, zero, memReady,
        output pcEn, iorD, memRead, memWrite, irWrite, memToReg, regDst,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
    );

    modport slave (
        output opcode, zero, memReady,
        input  pcEn, iorD, memRead, memWrite, irWrite, memToReg, regDst,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore main control FSM of the 8-bit multicycle processor: sequences fetch,
// decode, execute, memory and writeback and drives every datapath select/enable.
module mc_control_fsm (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    logic [3:0] state_q, state_d;

    // Strobes before the reset mask; reset must suppress writes even in FETCH.
    logic pc_en_raw, mem_read_raw, ir_write_raw, mem_write_raw, reg_write_raw;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_FETCH;
            end
            S_MEMRD:    state_d = bus.memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = bus.memReady ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en_raw     = 1'b0;
        mem_read_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        bus.iorD      = 1'b0;
        bus.memToReg  = 1'b0;
        bus.regDst    = 1'b0;
        bus.aluSrcA   = 1'b0;
        bus.aluSrcB   = 2'b00;
        bus.aluOp     = 2'b00;
        bus.pcSource  = 2'b00;
        bus.illegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                bus.aluSrcB  = 2'b01;
                ir_write_raw = bus.memReady;
                pc_en_raw    = bus.memReady;
            end
            S_DECODE: begin
                bus.aluSrcB   = 2'b11;
                bus.illegalOp = (bus.opcode == 3'b110) || (bus.opcode == 3'b111);
            end
            S_MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                bus.iorD     = 1'b1;
            end
            S_MEMWB: begin
                bus.memToReg  = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                bus.iorD      = 1'b1;
            end
            S_EXECUTE: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b10;
            end
            S_ALUWB: begin
                bus.regDst    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                bus.aluSrcA  = 1'b1;
                bus.aluOp    = 2'b01;
                bus.pcSource = 2'b01;
                pc_en_raw    = bus.zero;
            end
            S_ADDIEXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            S_ADDIWB:   reg_write_raw = 1'b1;
            S_JUMP: begin
                bus.pcSource = 2'b10;
                pc_en_raw    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcEn     = pc_en_raw     & ~reset;
    assign bus.memRead  = mem_read_raw  & ~reset;
    assign bus.irWrite  = ir_write_raw  & ~reset;
    assign bus.memWrite = mem_write_raw & ~reset;
    assign bus.regWrite = reg_write_raw & ~reset;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues hand-written expected
// output vectors per cycle, a negedge monitor pops and compares them.
module tb_mc_control_fsm;
    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } sb_entry_t;

    //                               st    pc io mr mw ir m2 rd rw sa  srcB   aluOp  pcSrc  ill
    localparam exp_t E_RST      = '{4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0};
    localparam exp_t E_F_STALL  = '{4'd0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0};
    localparam exp_t E_F_RDY    = '{4'd0,  1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0};
    localparam exp_t E_DEC      = '{4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0};
    localparam exp_t E_DEC_ILL  = '{4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1};
    localparam exp_t E_MEMADR   = '{4'd2,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0};
    localparam exp_t E_MEMRD    = '{4'd3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
    localparam exp_t E_MEMWB    = '{4'd4,  0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0};
    localparam exp_t E_MEMWR    = '{4'd5,  0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
    localparam exp_t E_EXEC     = '{4'd6,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0};
    localparam exp_t E_ALUWB    = '{4'd7,  0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0};
    localparam exp_t E_BR_T     = '{4'd8,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0};
    localparam exp_t E_BR_N     = '{4'd8,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0};
    localparam exp_t E_ADDIEX   = '{4'd9,  0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0};
    localparam exp_t E_ADDIWB   = '{4'd10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0};
    localparam exp_t E_JUMP     = '{4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0};

    logic clk;
    logic reset;
    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    sb_entry_t exp_q[$];
    int        n_vec  = 0;
    int        n_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic rst_v, input logic [2:0] op, input logic z,
                        input logic mr, input exp_t e, input string tag);
        sb_entry_t ent;
        @(posedge clk);
        #1;
        reset        = rst_v;
        bus.opcode   = op;
        bus.zero     = z;
        bus.memReady = mr;
        ent.e   = e;
        ent.tag = tag;
        exp_q.push_back(ent);
    endtask

    // Monitor: compares one queued vector per cycle, away from the active edge.
    initial begin
        sb_entry_t ent;
        exp_t      act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                act = '{bus.state, bus.pcEn, bus.iorD, bus.memRead, bus.memWrite,
                        bus.irWrite, bus.memToReg, bus.regDst, bus.regWrite,
                        bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.pcSource,
                        bus.illegalOp};
                n_vec++;
                if (act !== ent.e) begin
                    n_miss++;
                    $display("FAIL %s: got %b want %b (state %0d want %0d)",
                             ent.tag, act, ent.e, act.state, ent.e.state);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.opcode   = 3'b000;
        bus.zero     = 1'b0;
        bus.memReady = 1'b0;

        step(1, 3'b000, 0, 0, E_RST,     "reset_hold0");
        step(1, 3'b000, 0, 1, E_RST,     "reset_hold1");

        // R-type: 0,1,6,7
        step(0, 3'b000, 0, 1, E_F_RDY,   "r_fetch");
        step(0, 3'b000, 0, 1, E_DEC,     "r_decode");
        step(0, 3'b000, 0, 1, E_EXEC,    "r_execute");
        step(0, 3'b000, 0, 1, E_ALUWB,   "r_aluwb");

        // LW with two stall cycles in MEMRD: 0,1,2,3,3,3,4
        step(0, 3'b001, 0, 1, E_F_RDY,   "lw_fetch");
        step(0, 3'b001, 0, 1, E_DEC,     "lw_decode");
        step(0, 3'b001, 0, 1, E_MEMADR,  "lw_memadr");
        step(0, 3'b001, 0, 0, E_MEMRD,   "lw_memrd_stall0");
        step(0, 3'b001, 0, 0, E_MEMRD,   "lw_memrd_stall1");
        step(0, 3'b001, 0, 1, E_MEMRD,   "lw_memrd_ready");
        step(0, 3'b001, 0, 1, E_MEMWB,   "lw_memwb");

        // SW, no stall
        step(0, 3'b010, 0, 1, E_F_RDY,   "sw_fetch");
        step(0, 3'b010, 0, 1, E_DEC,     "sw_decode");
        step(0, 3'b010, 0, 1, E_MEMADR,  "sw_memadr");
        step(0, 3'b010, 0, 1, E_MEMWR,   "sw_memwr");

        // BEQ taken then not taken
        step(0, 3'b011, 1, 1, E_F_RDY,   "beq_t_fetch");
        step(0, 3'b011, 1, 1, E_DEC,     "beq_t_decode");
        step(0, 3'b011, 1, 1, E_BR_T,    "beq_t_branch");
        step(0, 3'b011, 0, 1, E_F_RDY,   "beq_n_fetch");
        step(0, 3'b011, 0, 1, E_DEC,     "beq_n_decode");
        step(0, 3'b011, 0, 1, E_BR_N,    "beq_n_branch");

        // ADDI
        step(0, 3'b100, 0, 1, E_F_RDY,   "addi_fetch");
        step(0, 3'b100, 0, 1, E_DEC,     "addi_decode");
        step(0, 3'b100, 0, 1, E_ADDIEX,  "addi_exec");
        step(0, 3'b100, 0, 1, E_ADDIWB,  "addi_wb");

        // Illegal opcodes 110 and 111 return straight to FETCH
        step(0, 3'b110, 0, 1, E_F_RDY,   "ill6_fetch");
        step(0, 3'b110, 0, 1, E_DEC_ILL, "ill6_decode");
        step(0, 3'b111, 0, 1, E_F_RDY,   "ill7_fetch");
        step(0, 3'b111, 0, 1, E_DEC_ILL, "ill7_decode");

        // Jump with FETCH stalled three cycles
        step(0, 3'b101, 0, 0, E_F_STALL, "j_fetch_stall0");
        step(0, 3'b101, 0, 0, E_F_STALL, "j_fetch_stall1");
        step(0, 3'b101, 0, 0, E_F_STALL, "j_fetch_stall2");
        step(0, 3'b101, 0, 1, E_F_RDY,   "j_fetch_ready");
        step(0, 3'b101, 0, 1, E_DEC,     "j_decode");
        step(0, 3'b101, 1, 1, E_JUMP,    "j_jump");

        // Store stalled in MEMWR, then reset asserted mid-cycle aborts it
        step(0, 3'b010, 0, 1, E_F_RDY,   "swr_fetch");
        step(0, 3'b010, 0, 1, E_DEC,     "swr_decode");
        step(0, 3'b010, 0, 0, E_MEMADR,  "swr_memadr");
        step(0, 3'b010, 0, 0, E_MEMWR,   "swr_memwr_stall");
        step(1, 3'b010, 0, 0, E_RST,     "swr_reset_abort");
        step(0, 3'b000, 0, 1, E_F_RDY,   "post_reset_fetch");
        step(0, 3'b000, 0, 1, E_DEC,     "post_reset_decode");
        step(0, 3'b000, 0, 1, E_EXEC,    "post_reset_execute");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d vectors left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
